ofdm_tx_symbol_framer: RTL and testbench
========================================

// Module: ofdm_tx_symbol_framer
// PURPOSE
// Transmit-side counterpart of the OFDM RX path. Accepts time-domain OFDM symbol samples
// (raw_symbol_length_c per symbol, produced by the TX IFFT) into a ping-pong buffer.
// Emits frames of sequence_length_c symbols, each as a cyclic prefix plus a symbol body.
// Output is paced at one I/Q sample every osr_c clocks, matching the RX input sample rate.
// PARAMETERS
// sample_bit_width_c   12   width of each I and Q sample (signed)
// symbol_length_c      320  output samples per symbol, including CP (must be > raw_symbol_length_c)
// raw_symbol_length_c  256  body samples per symbol; CP length = symbol_length_c - raw_symbol_length_c
// osr_c                4    clocks per output sample (>= 2)
// sequence_length_c    20   symbols per frame
// PORTS
// sys_clk        in   1    system clock, rising edge
// sys_rst        in   1    asynchronous reset, active high
// sys_init       in   1    synchronous soft clear: abort frame, flush both banks
// tx_start       in   1    one-cycle pulse: start a frame (ignored while tx_busy)
// in_data_i/q    in   W    input symbol sample, W = sample_bit_width_c
// in_data_valid  in   1    input sample valid
// in_data_ready  out  1    buffer can accept; transfer occurs when valid && ready
// tx_data_i/q    out  W    output sample; 0 when not valid
// tx_data_valid  out  1    one-cycle pulse per output sample
// tx_data_start  out  1    coincides with the first tx_data_valid of a frame
// tx_busy        out  1    frame in progress
// tx_underrun    out  1    sticky; set on underrun abort, cleared by next accepted tx_start
// BEHAVIOUR
// - Reset/sys_init: all outputs 0 except in_data_ready=1; state IDLE; banks empty;
//   wr_bank=rd_bank=0; symbol count 0. Reset is honoured mid-frame with no residual output.
// - Buffer: 2 banks x raw_symbol_length_c entries. Writes fill wr_bank at addresses 0..N-1.
//   On the Nth write, full[wr_bank] is set and wr_bank toggles.
//   in_data_ready = !full[wr_bank]. Filling is allowed in any state, including IDLE.
// - A bank is released (full cleared, rd_bank toggles) when its last body read is issued.
//   When both banks were full, in_data_ready rises the following cycle.
// - FSM: IDLE -> (tx_start) WAIT_FILL -> (full[rd_bank]) CP -> BODY -> CP|IDLE.
//   * CP: reads addresses raw-cp .. raw-1 (default 192..255).
//   * BODY: reads addresses 0..raw-1.
//   * The pace counter restarts at 0 on entry to CP from WAIT_FILL; one read per osr_c clocks.
//   * End of BODY with count == sequence_length_c-1: go to IDLE; tx_busy drops with the last
//     tx_data_valid.
//   * End of BODY otherwise: if full[other bank] is set (sampled on the cycle of the last body
//     read), continue to CP with no gap in cadence.
//   * End of BODY with the other bank empty: underrun. Set tx_underrun, go to IDLE, flush banks.
// - Latency: tx_data_valid is asserted 2 clocks after a read is issued (sync RAM + output
//   register). The first pulse occurs 3 clocks after the bank becomes full in WAIT_FILL.
//   Later pulses are spaced exactly osr_c clocks apart within a frame.
// - tx_busy is 1 from the cycle after an accepted tx_start until the last sample of the frame
//   or an abort.
// - Simultaneous events on one cycle:
//   * sys_init beats tx_start and all writes.
//   * Releasing rd_bank and completing a write to the other bank are both applied.
//   * tx_start while tx_busy has no effect.
// - No arithmetic on sample data: samples pass bit-exact. Counters are sized with
//   $clog2(symbol_length_c), $clog2(sequence_length_c) and $clog2(osr_c).
// TESTING
// 1 Reset: assert sys_rst mid-frame -> all outputs 0 next edge; in_data_ready=1; no tx_data_valid after release.
// 2 Frame, sequence_length_c=2: preload ramp 0..511, then pulse tx_start.
//   -> 640 pulses, 4 clocks apart, values 192..255,0..255,448..511,256..511.
//   -> tx_data_start only on the first pulse; tx_busy=0 after the last.
// 3 Backpressure: drive in_data_valid=1 constantly in IDLE -> exactly 512 samples accepted, then in_data_ready=0.
// 4 Underrun: sequence_length_c=2, supply 256 samples, tx_start.
//   -> 320 pulses; then tx_underrun=1, tx_busy=0, in_data_ready=1.
//   -> next tx_start clears tx_underrun.
// 5 sys_init after 100 output samples -> tx_busy=0, no further pulses, banks empty (512 samples accepted again).
// 6 Streaming: sequence_length_c=20, feed 1 sample per 5 clocks.
//   -> 6400 gapless pulses, no underrun, output equals input with CPs inserted.

Source files
------------

// File: rtl/ofdm_tx_symbol_framer_if.sv
// ofdm_tx_symbol_framer_if: control, sample-input and framed-output signals of the symbol framer
interface ofdm_tx_symbol_framer_if #(parameter int sample_bit_width_c = 12);
  logic sys_init;
  logic tx_start;
  logic signed [sample_bit_width_c-1:0] in_data_i, in_data_q, tx_data_i, tx_data_q;
  logic in_data_valid, in_data_ready;
  logic tx_data_valid, tx_data_start, tx_busy, tx_underrun;
  modport master (
    output sys_init, tx_start, in_data_i, in_data_q, in_data_valid,
    input in_data_ready, tx_data_i, tx_data_q, tx_data_valid, tx_data_start, tx_busy, tx_underrun
  );
  modport slave (
    input sys_init, tx_start, in_data_i, in_data_q, in_data_valid,
    output in_data_ready, tx_data_i, tx_data_q, tx_data_valid, tx_data_start, tx_busy, tx_underrun
  );
endinterface

// File: rtl/ofdm_tx_symbol_framer.sv
// ofdm_tx_symbol_framer: ping-pong buffered symbol framer inserting cyclic prefixes, one sample per osr_c clocks
module ofdm_tx_symbol_framer #(
  parameter int sample_bit_width_c = 12,
  parameter int symbol_length_c = 320,
  parameter int raw_symbol_length_c = 256,
  parameter int osr_c = 4,
  parameter int sequence_length_c = 20
) (
  input logic sys_clk,
  input logic sys_rst,
  ofdm_tx_symbol_framer_if.slave bus
);
  localparam int cp_c = symbol_length_c - raw_symbol_length_c;
  localparam int cp_base_c = raw_symbol_length_c - cp_c;
  localparam int iw = $clog2(symbol_length_c);
  localparam int sw = $clog2(sequence_length_c);
  localparam int pw = $clog2(osr_c);
  localparam int aw = $clog2(raw_symbol_length_c);
  typedef enum logic [1:0] {IDLE, WAIT_FILL, CP, BODY} state_t;
  state_t state, state_n;
  logic [pw-1:0] pace;
  logic [iw-1:0] idx;
  logic [sw-1:0] sym;
  logic [aw-1:0] wr_addr;
  logic [aw:0] rd_addr;
  logic wr_bank, rd_bank;
  logic [1:0] full;
  logic [2*sample_bit_width_c-1:0] mem [2*raw_symbol_length_c];
  logic [2*sample_bit_width_c-1:0] rd_data;
  logic first, rd_v, rd_first, underrun_r;
  logic active, rd_issue, cp_last, body_last, rel_bank, frame_end, underrun, start_ok, wr_fire, wr_last;
  assign active = state == CP || state == BODY;
  assign rd_issue = active && pace == '0;
  assign cp_last = state == CP && idx == iw'(cp_c - 1);
  assign body_last = state == BODY && idx == iw'(raw_symbol_length_c - 1);
  assign rel_bank = rd_issue && body_last;
  assign frame_end = rel_bank && sym == sw'(sequence_length_c - 1);
  // the other bank must already be full on the very cycle of the last body read
  assign underrun = rel_bank && !frame_end && !full[~rd_bank];
  assign start_ok = bus.tx_start && !bus.tx_busy;
  assign wr_fire = bus.in_data_valid && bus.in_data_ready && !bus.sys_init;
  assign wr_last = wr_addr == aw'(raw_symbol_length_c - 1);
  assign rd_addr = {rd_bank, state == CP ? aw'(idx + iw'(cp_base_c)) : aw'(idx)};
  assign bus.in_data_ready = !full[wr_bank];
  assign bus.tx_busy = state != IDLE || rd_v || bus.tx_data_valid;
  assign bus.tx_underrun = underrun_r;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start_ok ? WAIT_FILL : IDLE;
      WAIT_FILL: state_n = full[rd_bank] ? CP : WAIT_FILL;
      CP: state_n = rd_issue && cp_last ? BODY : CP;
      BODY: state_n = !rel_bank ? BODY : (frame_end || underrun) ? IDLE : CP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) state <= IDLE;
    else state <= bus.sys_init ? IDLE : state_n;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      {pace, idx, sym, first, rd_v, rd_first, underrun_r, wr_addr, wr_bank, rd_bank, full} <= '0;
      {bus.tx_data_i, bus.tx_data_q, bus.tx_data_valid, bus.tx_data_start} <= '0;
    end else if (bus.sys_init) begin
      {pace, idx, sym, first, rd_v, rd_first, underrun_r, wr_addr, wr_bank, rd_bank, full} <= '0;
      {bus.tx_data_i, bus.tx_data_q, bus.tx_data_valid, bus.tx_data_start} <= '0;
    end else begin
      pace <= active ? (pace == pw'(osr_c - 1) ? '0 : pace + 1'b1) : '0;
      idx <= !active ? '0 : !rd_issue ? idx : (cp_last || body_last) ? '0 : idx + 1'b1;
      sym <= start_ok ? '0 : (rel_bank && !frame_end) ? sym + 1'b1 : sym;
      first <= start_ok || (first && !rd_issue);
      rd_v <= rd_issue;
      rd_first <= rd_issue && first;
      bus.tx_data_valid <= rd_v;
      bus.tx_data_start <= rd_first;
      {bus.tx_data_i, bus.tx_data_q} <= rd_v ? rd_data : '0;
      underrun_r <= !start_ok && (underrun_r || underrun);
      if (underrun) {wr_addr, wr_bank, rd_bank, full} <= '0;
      else begin
        if (wr_fire) begin
          wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
          if (wr_last) begin
            full[wr_bank] <= 1'b1;
            wr_bank <= !wr_bank;
          end
        end
        if (rel_bank) begin
          full[rd_bank] <= 1'b0;
          rd_bank <= !rd_bank;
        end
      end
    end
  always_ff @(posedge sys_clk) begin
    if (wr_fire) mem[{wr_bank, wr_addr}] <= {bus.in_data_i, bus.in_data_q};
    if (rd_issue) rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_ofdm_tx_symbol_framer.sv
// tb_ofdm_tx_symbol_framer: randomized scenarios checked against an index-arithmetic model of CP framing
module tb_ofdm_tx_symbol_framer;
  localparam int W = 12, RAW = 256, SYM = 320, CP = SYM - RAW, OSR = 4;
  typedef struct { logic [2*W-1:0] d; int cyc; logic st; } pulse_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0, viol = 0, n2 = 0, acc20 = 0;
  logic [2*W-1:0] in2 [1024];
  logic [2*W-1:0] in20 [20*RAW];
  pulse_t q2[$], q20[$];
  ofdm_tx_symbol_framer_if #(.sample_bit_width_c(W)) a2 ();
  ofdm_tx_symbol_framer_if #(.sample_bit_width_c(W)) a20 ();
  ofdm_tx_symbol_framer #(.sample_bit_width_c(W), .sequence_length_c(2)) dut2 (.sys_clk(clk), .sys_rst(rst), .bus(a2));
  ofdm_tx_symbol_framer #(.sample_bit_width_c(W), .sequence_length_c(20)) dut20 (.sys_clk(clk), .sys_rst(rst), .bus(a20));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (a2.tx_data_valid === 1'b1) q2.push_back('{{a2.tx_data_i, a2.tx_data_q}, cyc, a2.tx_data_start});
    else if ({a2.tx_data_i, a2.tx_data_q, a2.tx_data_start} !== '0) viol++;
    if (a20.tx_data_valid === 1'b1) q20.push_back('{{a20.tx_data_i, a20.tx_data_q}, cyc, a20.tx_data_start});
    else if ({a20.tx_data_i, a20.tx_data_q, a20.tx_data_start} !== '0) viol++;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  // output sample j of a frame comes from input sample: symbol base + (CP tail or body offset)
  function automatic int src_idx(input int j);
    int s, p;
    s = j / SYM;
    p = j % SYM;
    return s * RAW + (p < CP ? RAW - CP + p : p - CP);
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic feed2(input int n, input int budget, output int acc);
    acc = 0;
    for (int t = 0; t < budget && acc < n; t++) begin
      @(negedge clk);
      a2.in_data_i = W'(n2);
      a2.in_data_q = W'($urandom);
      a2.in_data_valid = 1'b1;
      if (a2.in_data_ready === 1'b1) begin
        in2[n2] = {a2.in_data_i, a2.in_data_q};
        n2++;
        acc++;
      end
    end
    @(negedge clk) a2.in_data_valid = 1'b0;
  endtask
  task automatic start2();
    @(negedge clk) a2.tx_start = 1'b1;
    @(negedge clk) a2.tx_start = 1'b0;
  endtask
  task automatic init2();
    @(negedge clk) a2.sys_init = 1'b1;
    @(negedge clk) a2.sys_init = 1'b0;
  endtask
  task automatic wait2(input int n, input int budget);
    for (int t = 0; t < budget && q2.size() < n; t++) @(negedge clk);
  endtask
  task automatic test_reset();
    int acc;
    tick(3);
    checks++;
    if ({a2.tx_data_valid, a2.tx_data_start, a2.tx_busy, a2.tx_underrun, a2.tx_data_i, a2.tx_data_q} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {a2.tx_data_valid, a2.tx_data_start, a2.tx_busy, a2.tx_underrun, a2.tx_data_i, a2.tx_data_q});
    end
    checks++;
    if (a2.in_data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a2.in_data_ready); end
    rst = 1'b0;
    feed2(256, 400, acc);
    start2();
    wait2(20, 400);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({a2.tx_data_valid, a2.tx_data_start, a2.tx_busy, a2.tx_underrun, a2.tx_data_i, a2.tx_data_q} !== '0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h want 0", {a2.tx_data_valid, a2.tx_data_start, a2.tx_busy, a2.tx_underrun, a2.tx_data_i, a2.tx_data_q});
    end
    checks++;
    if (a2.in_data_ready !== 1'b1) begin errors++; $display("FAIL midframe_reset_ready: got %b want 1", a2.in_data_ready); end
    @(negedge clk) rst = 1'b0;
    q2.delete();
    n2 = 0;
    tick(100);
    checks++;
    if (q2.size() !== 0) begin errors++; $display("FAIL reset_residual_pulses: got %0d want 0", q2.size()); end
    checks++;
    if (a2.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a2.tx_busy); end
  endtask
  task automatic test_frame();
    int acc, s;
    n2 = 0;
    q2.delete();
    feed2(512, 1200, acc);
    checks++;
    if (acc !== 512) begin errors++; $display("FAIL frame_preload: got %0d want 512", acc); end
    checks++;
    if (a2.in_data_ready !== 1'b0) begin errors++; $display("FAIL frame_ready_full: got %b want 0", a2.in_data_ready); end
    @(negedge clk) a2.tx_start = 1'b1;
    s = cyc;
    @(negedge clk) a2.tx_start = 1'b0;
    checks++;
    if (a2.tx_busy !== 1'b1) begin errors++; $display("FAIL frame_busy_start: got %b want 1", a2.tx_busy); end
    wait2(640, 3200);
    tick(20);
    checks++;
    if (q2.size() !== 640) begin errors++; $display("FAIL frame_count: got %0d want 640", q2.size()); end
    if (q2.size() > 0) begin
      checks++;
      if (q2[0].cyc !== s + 4) begin errors++; $display("FAIL frame_latency: got %0d want %0d", q2[0].cyc - s, 4); end
    end
    for (int j = 0; j < q2.size(); j++) begin
      checks++;
      if (q2[j].d !== in2[src_idx(j)]) begin errors++; $display("FAIL frame_data[%0d]: got %h want %h", j, q2[j].d, in2[src_idx(j)]); break; end
    end
    for (int j = 1; j < q2.size(); j++) begin
      checks++;
      if (q2[j].cyc - q2[j-1].cyc !== OSR) begin errors++; $display("FAIL frame_spacing[%0d]: got %0d want %0d", j, q2[j].cyc - q2[j-1].cyc, OSR); break; end
    end
    for (int j = 0; j < q2.size(); j++) begin
      checks++;
      if (q2[j].st !== (j == 0)) begin errors++; $display("FAIL frame_start_flag[%0d]: got %b want %b", j, q2[j].st, j == 0); break; end
    end
    checks++;
    if ({a2.tx_busy, a2.tx_underrun, a2.in_data_ready} !== 3'b001) begin
      errors++;
      $display("FAIL frame_end_status busy/underrun/ready: got %b want 001", {a2.tx_busy, a2.tx_underrun, a2.in_data_ready});
    end
  endtask
  task automatic test_backpressure();
    int acc;
    n2 = 0;
    feed2(1000, 700, acc);
    checks++;
    if (acc !== 512) begin errors++; $display("FAIL backpressure_accepted: got %0d want 512", acc); end
    checks++;
    if (a2.in_data_ready !== 1'b0) begin errors++; $display("FAIL backpressure_ready: got %b want 0", a2.in_data_ready); end
  endtask
  task automatic test_init_abort();
    int acc;
    q2.delete();
    start2();
    wait2(100, 1000);
    a2.sys_init = 1'b1;
    @(negedge clk) a2.sys_init = 1'b0;
    tick(60);
    checks++;
    if (q2.size() !== 100) begin errors++; $display("FAIL init_pulse_count: got %0d want 100", q2.size()); end
    for (int j = 0; j < q2.size(); j++) begin
      checks++;
      if (q2[j].d !== in2[src_idx(j)]) begin errors++; $display("FAIL init_data[%0d]: got %h want %h", j, q2[j].d, in2[src_idx(j)]); break; end
    end
    checks++;
    if ({a2.tx_busy, a2.in_data_ready} !== 2'b01) begin errors++; $display("FAIL init_status busy/ready: got %b want 01", {a2.tx_busy, a2.in_data_ready}); end
    n2 = 0;
    feed2(1000, 700, acc);
    checks++;
    if (acc !== 512) begin errors++; $display("FAIL init_refill: got %0d want 512", acc); end
  endtask
  task automatic test_underrun();
    int acc;
    init2();
    n2 = 0;
    q2.delete();
    feed2(256, 400, acc);
    start2();
    wait2(320, 2000);
    tick(10);
    checks++;
    if (q2.size() !== 320) begin errors++; $display("FAIL underrun_count: got %0d want 320", q2.size()); end
    for (int j = 0; j < q2.size(); j++) begin
      checks++;
      if (q2[j].d !== in2[src_idx(j)]) begin errors++; $display("FAIL underrun_data[%0d]: got %h want %h", j, q2[j].d, in2[src_idx(j)]); break; end
    end
    checks++;
    if ({a2.tx_underrun, a2.tx_busy, a2.in_data_ready} !== 3'b101) begin
      errors++;
      $display("FAIL underrun_status underrun/busy/ready: got %b want 101", {a2.tx_underrun, a2.tx_busy, a2.in_data_ready});
    end
    start2();
    checks++;
    if ({a2.tx_underrun, a2.tx_busy} !== 2'b01) begin errors++; $display("FAIL underrun_clear underrun/busy: got %b want 01", {a2.tx_underrun, a2.tx_busy}); end
    init2();
  endtask
  task automatic test_streaming();
    q20.delete();
    fork
      begin
        for (int k = 0; k < 20 * RAW; k++) begin
          int stall;
          stall = 0;
          do begin
            @(negedge clk);
            a20.in_data_i = W'(k);
            a20.in_data_q = W'($urandom);
            a20.in_data_valid = 1'b1;
            stall++;
          end while (a20.in_data_ready !== 1'b1 && stall < 4000);
          in20[k] = {a20.in_data_i, a20.in_data_q};
          acc20++;
          repeat (4) begin
            @(negedge clk);
            a20.in_data_valid = 1'b0;
          end
        end
      end
      begin
        for (int t = 0; t < 4000 && acc20 < 512; t++) @(negedge clk);
        @(negedge clk) a20.tx_start = 1'b1;
        @(negedge clk) a20.tx_start = 1'b0;
        for (int t = 0; t < 30000 && q20.size() < 6400; t++) @(negedge clk);
      end
    join
    tick(10);
    checks++;
    if (q20.size() !== 6400) begin errors++; $display("FAIL stream_count: got %0d want 6400", q20.size()); end
    for (int j = 0; j < q20.size(); j++) begin
      checks++;
      if (q20[j].d !== in20[src_idx(j)]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", j, q20[j].d, in20[src_idx(j)]); break; end
    end
    for (int j = 1; j < q20.size(); j++) begin
      checks++;
      if (q20[j].cyc - q20[j-1].cyc !== OSR) begin errors++; $display("FAIL stream_spacing[%0d]: got %0d want %0d", j, q20[j].cyc - q20[j-1].cyc, OSR); break; end
    end
    for (int j = 0; j < q20.size(); j++) begin
      checks++;
      if (q20[j].st !== (j == 0)) begin errors++; $display("FAIL stream_start_flag[%0d]: got %b want %b", j, q20[j].st, j == 0); break; end
    end
    checks++;
    if ({a20.tx_underrun, a20.tx_busy} !== 2'b00) begin errors++; $display("FAIL stream_status underrun/busy: got %b want 00", {a20.tx_underrun, a20.tx_busy}); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL idle_output_nonzero: got %0d want 0", viol); end
  endtask
  initial begin
    {a2.sys_init, a2.tx_start, a2.in_data_i, a2.in_data_q, a2.in_data_valid} = '0;
    {a20.sys_init, a20.tx_start, a20.in_data_i, a20.in_data_q, a20.in_data_valid} = '0;
    test_reset();
    test_frame();
    test_backpressure();
    test_init_abort();
    test_underrun();
    test_streaming();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
